// File: rtl/sign_mag_addsub_serial.sv
// Digit-serial sign-magnitude adder/subtractor.
// Operands are accepted on a valid/ready handshake, compared for one cycle to
// pick the larger magnitude, then summed D bits per cycle on a single slice
// with a registered carry. The result is held until the consumer takes it.
module sign_mag_addsub_serial #(
    parameter int N = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic         a_sign,
    input  logic [N-1:0] a_mag,
    input  logic         b_sign,
    input  logic [N-1:0] b_mag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         res_sign,
    output logic [N-1:0] res_mag,
    output logic         res_ovf,
    output logic         res_zero
);

    localparam int SLICES = N / D;
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    generate
        if (N < 2 || (N % D) != 0) begin : g_bad_params
            $error("sign_mag_addsub_serial: need N >= 2 and N divisible by D");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CMP, ADD, DONE} state_t;

    state_t         state_q, state_d;
    logic           a_sign_q, a_sign_d;
    logic [N-1:0]   a_mag_q, a_mag_d;
    logic [N-1:0]   b_mag_q, b_mag_d;
    logic           eb_sign_q, eb_sign_d;   // sign of B after applying op
    logic           same_q, same_d;         // like signs -> true magnitude add
    logic           sign_q, sign_d;         // provisional result sign
    logic [N-1:0]   big_q, big_d;           // shifted right one digit per ADD cycle
    logic [N-1:0]   small_q, small_d;
    logic           carry_q, carry_d;
    logic [N-1:0]   sum_q, sum_d;           // sum digits shifted in from the top
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           res_sign_q, res_sign_d;
    logic [N-1:0]   res_mag_q, res_mag_d;
    logic           res_ovf_q, res_ovf_d;
    logic           res_zero_q, res_zero_d;

    logic [D:0]     slice_c;
    logic [N-1:0]   sum_next_c;
    logic           same_c;

    // Next-state and datapath logic for the accept/compare/add/hold sequence.
    always_comb begin
        state_d    = state_q;
        a_sign_d   = a_sign_q;
        a_mag_d    = a_mag_q;
        b_mag_d    = b_mag_q;
        eb_sign_d  = eb_sign_q;
        same_d     = same_q;
        sign_d     = sign_q;
        big_d      = big_q;
        small_d    = small_q;
        carry_d    = carry_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        res_sign_d = res_sign_q;
        res_mag_d  = res_mag_q;
        res_ovf_d  = res_ovf_q;
        res_zero_d = res_zero_q;
        slice_c    = '0;
        sum_next_c = '0;
        same_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sign_d  = a_sign;
                    a_mag_d   = a_mag;
                    b_mag_d   = b_mag;
                    eb_sign_d = b_sign ^ op;
                    state_d   = CMP;
                end
            end
            CMP: begin
                same_c = (a_sign_q == eb_sign_q);
                same_d = same_c;
                if (same_c) begin
                    big_d   = a_mag_q;
                    small_d = b_mag_q;
                    carry_d = 1'b0;
                    sign_d  = a_sign_q;
                end else if (a_mag_q >= b_mag_q) begin
                    // Subtract smaller from larger as big + ~small + 1.
                    big_d   = a_mag_q;
                    small_d = ~b_mag_q;
                    carry_d = 1'b1;
                    sign_d  = a_sign_q;
                end else begin
                    big_d   = b_mag_q;
                    small_d = ~a_mag_q;
                    carry_d = 1'b1;
                    sign_d  = eb_sign_q;
                end
                cnt_d   = '0;
                sum_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                slice_c    = {1'b0, big_q[D-1:0]} + {1'b0, small_q[D-1:0]}
                           + {{D{1'b0}}, carry_q};
                sum_next_c = (sum_q >> D) | (N'(slice_c[D-1:0]) << (N - D));
                big_d      = big_q >> D;
                small_d    = small_q >> D;
                sum_d      = sum_next_c;
                carry_d    = slice_c[D];
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Unlike-sign carry-out is just the two's-complement artefact.
                    res_mag_d  = sum_next_c;
                    res_ovf_d  = same_q & slice_c[D];
                    res_zero_d = (sum_next_c == '0);
                    res_sign_d = sign_q & (sum_next_c != '0);
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_sign_q   <= 1'b0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            eb_sign_q  <= 1'b0;
            same_q     <= 1'b0;
            sign_q     <= 1'b0;
            big_q      <= '0;
            small_q    <= '0;
            carry_q    <= 1'b0;
            sum_q      <= '0;
            cnt_q      <= '0;
            res_sign_q <= 1'b0;
            res_mag_q  <= '0;
            res_ovf_q  <= 1'b0;
            res_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sign_q   <= a_sign_d;
            a_mag_q    <= a_mag_d;
            b_mag_q    <= b_mag_d;
            eb_sign_q  <= eb_sign_d;
            same_q     <= same_d;
            sign_q     <= sign_d;
            big_q      <= big_d;
            small_q    <= small_d;
            carry_q    <= carry_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            res_sign_q <= res_sign_d;
            res_mag_q  <= res_mag_d;
            res_ovf_q  <= res_ovf_d;
            res_zero_q <= res_zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res_sign  = res_sign_q;
    assign res_mag   = res_mag_q;
    assign res_ovf   = res_ovf_q;
    assign res_zero  = res_zero_q;

endmodule

// File: tb/tb_sign_mag_addsub_serial.sv
// Scoreboard bench for sign_mag_addsub_serial: one instance with D=4, one with D=1.
module tb_sign_mag_addsub_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv0, ir0, op0, as0, bs0, ov0, or0, rs0, ro0, rz0;
    logic [7:0] am0, bm0, rm0;
    logic       iv1, ir1, op1, as1, bs1, ov1, or1, rs1, ro1, rz1;
    logic [7:0] am1, bm1, rm1;

    sign_mag_addsub_serial #(.N(8), .D(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .op(op0),
        .a_sign(as0), .a_mag(am0), .b_sign(bs0), .b_mag(bm0),
        .out_valid(ov0), .out_ready(or0), .res_sign(rs0), .res_mag(rm0),
        .res_ovf(ro0), .res_zero(rz0));

    sign_mag_addsub_serial #(.N(8), .D(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op(op1),
        .a_sign(as1), .a_mag(am1), .b_sign(bs1), .b_mag(bm1),
        .out_valid(ov1), .out_ready(or1), .res_sign(rs1), .res_mag(rm1),
        .res_ovf(ro1), .res_zero(rz1));

    typedef struct {
        logic       s;
        logic [7:0] m;
        logic       o;
        logic       z;
        int         acc;
        int         lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rise0 = 0, rise1 = 0;
    bit   seen0 = 0, seen1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int sel, input logic s, input logic [7:0] m,
                       input logic o, input logic z, input int rise);
        exp_t e;
        if (sel == 0) begin
            if (q0.size() == 0) begin chk("dut0_unexpected_out", 1, 0); return; end
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) begin chk("dut1_unexpected_out", 1, 0); return; end
            e = q1.pop_front();
        end
        chk($sformatf("dut%0d_sign", sel), {31'd0, s}, {31'd0, e.s});
        chk($sformatf("dut%0d_mag", sel), {24'd0, m}, {24'd0, e.m});
        chk($sformatf("dut%0d_ovf", sel), {31'd0, o}, {31'd0, e.o});
        chk($sformatf("dut%0d_zero", sel), {31'd0, z}, {31'd0, e.z});
        chk($sformatf("dut%0d_latency", sel), rise - e.acc, e.lat);
    endtask

    // Monitors: note the first valid cycle, compare on the handshake cycle.
    always @(negedge clk) begin
        if (!ov0) seen0 = 0;
        else begin
            if (!seen0) begin seen0 = 1; rise0 = cyc; end
            if (or0) mon(0, rs0, rm0, ro0, rz0, rise0);
        end
    end

    always @(negedge clk) begin
        if (!ov1) seen1 = 0;
        else begin
            if (!seen1) begin seen1 = 1; rise1 = cyc; end
            if (or1) mon(1, rs1, rm1, ro1, rz1, rise1);
        end
    end

    task automatic send(input int sel, input bit push, input logic op, input logic as,
                        input logic [7:0] am, input logic bs, input logic [7:0] bm,
                        input logic es, input logic [7:0] em, input logic eo,
                        input logic ez, input int lat);
        int   n;
        bit   rdy;
        exp_t e;
        @(posedge clk); #1;
        if (sel == 0) begin op0 = op; as0 = as; am0 = am; bs0 = bs; bm0 = bm; iv0 = 1; end
        else          begin op1 = op; as1 = as; am1 = am; bs1 = bs; bm1 = bm; iv1 = 1; end
        n = 0;
        rdy = 0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            n++;
            rdy = (sel == 0) ? ir0 : ir1;
        end
        if (!rdy) begin
            chk("accept_timeout", 0, 1);
            if (sel == 0) iv0 = 0; else iv1 = 0;
            return;
        end
        e.s = es; e.m = em; e.o = eo; e.z = ez; e.acc = cyc + 1; e.lat = lat;
        @(posedge clk); #1;
        // Scramble inputs after the accept edge; the DUT must not look at them.
        if (sel == 0) begin iv0 = 0; op0 = ~op; as0 = ~as; am0 = 8'hA5; bs0 = ~bs; bm0 = 8'h5A; end
        else          begin iv1 = 0; op1 = ~op; as1 = ~as; am1 = 8'hA5; bs1 = ~bs; bm1 = 8'h5A; end
        if (push) begin
            if (sel == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 0, 1);
    endtask

    task automatic wait_valid0(output bit ok);
        int n = 0;
        ok = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            n++;
            ok = ov0;
        end
        if (!ok) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       cs, co, cz;
        logic [7:0] cm;
        bit         ok;

        rst = 1;
        iv0 = 0; op0 = 0; as0 = 0; am0 = 0; bs0 = 0; bm0 = 0; or0 = 1;
        iv1 = 0; op1 = 0; as1 = 0; am1 = 0; bs1 = 0; bm1 = 0; or1 = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, ov0}, 0);
        chk("rst_res_mag", {24'd0, rm0}, 0);
        chk("rst_res_flags", {29'd0, rs0, ro0, rz0}, 0);
        rst = 0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, ir0}, 1);

        // sel push op  as am   bs bm   | sign mag ovf zero lat
        send(0, 1, 0, 0, 8'd5,   0, 8'd3,   0, 8'd8,   0, 0, 3);  // +5 + +3
        send(0, 1, 1, 0, 8'd5,   0, 8'd9,   1, 8'd4,   0, 0, 3);  // +5 - +9
        send(0, 1, 0, 1, 8'd7,   0, 8'd7,   0, 8'd0,   0, 1, 3);  // -7 + +7
        send(0, 1, 0, 1, 8'd0,   1, 8'd0,   0, 8'd0,   0, 1, 3);  // -0 + -0
        send(0, 1, 0, 0, 8'd200, 0, 8'd100, 0, 8'd44,  1, 0, 3);  // +200 + +100
        send(0, 1, 1, 1, 8'd200, 0, 8'd100, 1, 8'd44,  1, 0, 3);  // -200 - +100
        send(0, 1, 1, 0, 8'd100, 1, 8'd27,  0, 8'd127, 0, 0, 3);  // +100 - -27
        send(0, 1, 0, 1, 8'd20,  0, 8'd50,  0, 8'd30,  0, 0, 3);  // -20 + +50
        send(0, 1, 0, 0, 8'd255, 1, 8'd0,   0, 8'd255, 0, 0, 3);  // +255 + -0
        send(0, 1, 0, 0, 8'd255, 0, 8'd1,   0, 8'd0,   1, 1, 3);  // +255 + +1
        send(0, 1, 1, 1, 8'd128, 1, 8'd128, 0, 8'd0,   0, 1, 3);  // -128 - -128
        drain();

        // Consumer stalls for five cycles: result held, no new operands taken.
        or0 = 0;
        send(0, 1, 0, 1, 8'd3, 1, 8'd4, 1, 8'd7, 0, 0, 3);      // -3 + -4
        wait_valid0(ok);
        cs = rs0; cm = rm0; co = ro0; cz = rz0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_res_stable", {21'd0, rs0, rm0, ro0, rz0, ov0}, {21'd0, cs, cm, co, cz, 1'b1});
            chk("stall_in_ready", {31'd0, ir0}, 0);
        end
        @(posedge clk); #1;
        or0 = 1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_handshake", {31'd0, ir0}, 1);
        send(0, 1, 1, 0, 8'd10, 0, 8'd3, 0, 8'd7, 0, 0, 3);      // +10 - +3
        drain();

        // Reset while adding: nothing comes out, next operation is clean.
        send(0, 0, 0, 0, 8'd1, 0, 8'd1, 0, 8'd2, 0, 0, 3);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("rst_add_out_valid", {31'd0, ov0}, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_add_in_ready", {31'd0, ir0}, 1);
        send(0, 1, 0, 0, 8'd12, 0, 8'd13, 0, 8'd25, 0, 0, 3);    // +12 + +13
        drain();

        // Reset while a result is waiting: out_valid drops without a clock.
        or0 = 0;
        send(0, 0, 0, 0, 8'd1, 0, 8'd2, 0, 8'd3, 0, 0, 3);
        wait_valid0(ok);
        #2 rst = 1;
        #1;
        chk("rst_done_out_valid", {31'd0, ov0}, 0);
        chk("rst_done_res_mag", {24'd0, rm0}, 0);
        @(negedge clk);
        rst = 0;
        or0 = 1;
        @(negedge clk);
        chk("rst_done_in_ready", {31'd0, ir0}, 1);

        // Single-bit digits: nine-cycle latency.
        send(1, 1, 0, 0, 8'd5,   0, 8'd3,   0, 8'd8,  0, 0, 9);  // +5 + +3
        send(1, 1, 1, 1, 8'd200, 0, 8'd100, 1, 8'd44, 1, 0, 9);  // -200 - +100
        send(1, 1, 1, 0, 8'd5,   0, 8'd9,   1, 8'd4,  0, 0, 9);  // +5 - +9
        drain();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
